// File: rtl/common_params.sv
// Shared widths and micro-opcode encodings for the execute stage and its
// memory-side blocks.
package common_params;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 32;
  localparam int REG_W    = 64;
  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] MICRO_SB = 6'h10;
  localparam logic [OPCODE_W-1:0] MICRO_SD = 6'h11;
  localparam logic [OPCODE_W-1:0] MICRO_SQ = 6'h12;
  localparam logic [OPCODE_W-1:0] MICRO_LB = 6'h18;
  localparam logic [OPCODE_W-1:0] MICRO_LD = 6'h19;
  localparam logic [OPCODE_W-1:0] MICRO_LQ = 6'h1A;

  function automatic logic is_load_op(input logic [OPCODE_W-1:0] op);
    return (op == MICRO_LB) || (op == MICRO_LD) || (op == MICRO_LQ);
  endfunction

endpackage

// File: rtl/data_memory_responder_load_aligner.sv
// Turns a raw memory word into a right-aligned, zero-extended load value and
// flags loads that would need bytes from the next word.
module load_aligner
  import common_params::*;
#(
  parameter int DW = common_params::DATA_W,
  parameter int RW = common_params::REG_W
) (
  input  logic [DW-1:0]       word,
  input  logic [2:0]          offset,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [RW-1:0]       data,
  output logic                misalign
);

  logic [DW-1:0] shifted;

  // The right shift zero-fills, so bytes past the word edge read as zero.
  always_comb begin
    shifted  = word >> {offset, 3'b000};
    data     = '0;
    misalign = 1'b0;
    case (opcode)
      MICRO_LB: data[7:0] = shifted[7:0];
      MICRO_LD: begin
        data[31:0] = shifted[31:0];
        misalign   = offset > 3'd4;
      end
      MICRO_LQ: begin
        data[DW-1:0] = shifted;
        misalign     = offset != 3'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: byte-masked stores, two-cycle aligned loads, and a
// post-reset sweep that zeroes the whole array before requests are accepted.
module data_memory_responder
#(
  parameter int DATA_W     = common_params::DATA_W,
  parameter int ADDR_W     = common_params::ADDR_W,
  parameter int WORDS_LOG2 = 12
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [ADDR_W-1:0]                   mem_addr,
  input  logic [DATA_W-1:0]                   st_data,
  input  logic [DATA_W/8-1:0]                 we,
  input  logic [2:0]                          ld_offset,
  input  logic [common_params::OPCODE_W-1:0]  opcode,
  output logic [common_params::REG_W-1:0]     ld_data,
  output logic                                ld_valid,
  output logic                                busy,
  output logic                                addr_err,
  output logic                                misalign_err
);

  import common_params::*;

  localparam int LANES = DATA_W / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state, state_next;
  logic [WORDS_LOG2-1:0]   clr_cnt;
  logic                    serving;
  logic                    in_range;
  logic                    is_store, is_load;
  logic [WORDS_LOG2-1:0]   ram_idx;
  logic [LANES-1:0]        ram_be;
  logic [DATA_W-1:0]       ram_wdata;
  logic [DATA_W-1:0]       ram_q;
  logic [DATA_W-1:0]       mem [0:(1<<WORDS_LOG2)-1];

  logic                    valid_a, range_err_a;
  logic [2:0]              offset_a;
  logic [OPCODE_W-1:0]     opcode_a;
  logic [REG_W-1:0]        aligned;
  logic                    misalign;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_cnt == '1) state_next = READY;
  end

  always_comb begin
    busy    = (state == CLEAR);
    serving = (state == READY);
  end

  always_comb begin
    in_range  = (mem_addr >> WORDS_LOG2) == '0;
    is_store  = serving && (we != '0);
    is_load   = serving && (we == '0) && is_load_op(opcode);
    ram_idx   = busy ? clr_cnt : mem_addr[WORDS_LOG2-1:0];
    ram_wdata = busy ? '0 : st_data;
    ram_be    = busy ? '1 : ((is_store && in_range) ? we : '0);
  end

  // Single port, registered read; a store's write lands before the next
  // cycle's read, so read-after-write needs no bypass.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (ram_be[i]) mem[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_q <= mem[ram_idx];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_a     <= 1'b0;
      range_err_a <= 1'b0;
      offset_a    <= '0;
      opcode_a    <= '0;
    end else begin
      valid_a     <= is_load;
      range_err_a <= !in_range;
      offset_a    <= ld_offset;
      opcode_a    <= opcode;
    end
  end

  load_aligner #(.DW(DATA_W), .RW(REG_W)) u_aligner (
    .word     (ram_q),
    .offset   (offset_a),
    .opcode   (opcode_a),
    .data     (aligned),
    .misalign (misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_data      <= '0;
      ld_valid     <= 1'b0;
      addr_err     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      ld_valid <= valid_a;
      if (valid_a) ld_data <= range_err_a ? '0 : aligned;
      if ((is_store || is_load) && !in_range) addr_err <= 1'b1;
      if (valid_a && misalign) misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with a 16-word array: sweep
// timing, store/load alignment, read-after-write, error flags and mid-run reset.
module tb_data_memory_responder;
  import common_params::*;

  localparam int WL = 4;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [ADDR_W-1:0]   mem_addr = '0;
  logic [DATA_W-1:0]   st_data = '0;
  logic [7:0]          we = '0;
  logic [2:0]          ld_offset = '0;
  logic [OPCODE_W-1:0] opcode = '0;
  logic [REG_W-1:0]    ld_data;
  logic                ld_valid, busy, addr_err, misalign_err;

  int checks = 0;
  int fails  = 0;

  data_memory_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS_LOG2(WL)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .mem_addr     (mem_addr),
    .st_data      (st_data),
    .we           (we),
    .ld_offset    (ld_offset),
    .opcode       (opcode),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .busy         (busy),
    .addr_err     (addr_err),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [7:0] w,
                               input logic [DATA_W-1:0] d, input logic [2:0] off,
                               input logic [OPCODE_W-1:0] op);
    mem_addr  = a;
    we        = w;
    st_data   = d;
    ld_offset = off;
    opcode    = op;
  endtask

  task automatic idle();
    applyStimulus('0, 8'h00, '0, 3'd0, 6'h00);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one load, confirm nothing arrives one cycle later and the result
  // arrives exactly two cycles after issue as a single-cycle pulse.
  task automatic doLoad(input string tag, input logic [ADDR_W-1:0] a,
                        input logic [2:0] off, input logic [OPCODE_W-1:0] op,
                        input logic [63:0] expected);
    applyStimulus(a, 8'h00, '0, off, op);
    step();
    idle();
    checkOutput({tag, "_early"}, {63'd0, ld_valid}, 64'd0);
    step();
    checkOutput({tag, "_valid"}, {63'd0, ld_valid}, 64'd1);
    checkOutput({tag, "_data"}, ld_data, expected);
  endtask

  task automatic doStore(input logic [ADDR_W-1:0] a, input logic [7:0] w,
                         input logic [DATA_W-1:0] d, input logic [OPCODE_W-1:0] op);
    applyStimulus(a, w, d, 3'd0, op);
    step();
    idle();
  endtask

  task automatic waitSweep(input string tag);
    int cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      checkOutput({tag, "_no_valid_in_sweep"}, {63'd0, ld_valid}, 64'd0);
      step();
    end
    checkOutput({tag, "_busy_cycles"}, 64'(cnt), 64'd16);
  endtask

  initial begin
    $display("[TB] start");
    idle();
    rstn = 1'b0;
    #3;
    checkOutput("rst_busy", {63'd0, busy}, 64'd1);
    checkOutput("rst_valid", {63'd0, ld_valid}, 64'd0);
    checkOutput("rst_data", ld_data, 64'd0);
    checkOutput("rst_addr_err", {63'd0, addr_err}, 64'd0);
    checkOutput("rst_mis_err", {63'd0, misalign_err}, 64'd0);
    step();
    step();
    rstn = 1'b1;
    waitSweep("sweep1");

    for (int i = 0; i < 16; i++)
      doLoad($sformatf("clr_lq%0d", i), ADDR_W'(i), 3'd0, MICRO_LQ, 64'd0);
    step();
    checkOutput("single_pulse", {63'd0, ld_valid}, 64'd0);

    doStore(3, 8'hFF, 64'h1122334455667788, MICRO_SQ);
    doLoad("sq_lq", 3, 3'd0, MICRO_LQ, 64'h1122334455667788);
    doLoad("lb_off5", 3, 3'd5, MICRO_LB, 64'h33);

    // Store immediately followed by a load of the same word.
    applyStimulus(3, 8'h04, 64'h0000_0000_00AB_0000, 3'd2, MICRO_SB);
    step();
    doLoad("raw_lq", 3, 3'd0, MICRO_LQ, 64'h1122334455AB7788);

    doLoad("ld_off4", 3, 3'd4, MICRO_LD, 64'h11223344);
    checkOutput("mis_clear", {63'd0, misalign_err}, 64'd0);
    doLoad("ld_off6", 3, 3'd6, MICRO_LD, 64'h1122);
    checkOutput("mis_set", {63'd0, misalign_err}, 64'd1);

    // A store paired with a load opcode is a store and yields no load result.
    applyStimulus(5, 8'h01, 64'h5A, 3'd0, MICRO_LQ);
    step();
    idle();
    step();
    checkOutput("st_with_ld_op", {63'd0, ld_valid}, 64'd0);
    doLoad("st_with_ld_op_lq", 5, 3'd0, MICRO_LQ, 64'h5A);

    checkOutput("addr_err_clear", {63'd0, addr_err}, 64'd0);
    doStore(16, 8'hFF, 64'hDEADBEEFCAFEF00D, MICRO_SQ);
    checkOutput("addr_err_set", {63'd0, addr_err}, 64'd1);
    doLoad("oor_alias0", 0, 3'd0, MICRO_LQ, 64'd0);
    doLoad("oor_lq", 16, 3'd0, MICRO_LQ, 64'd0);

    // Reset with a load in flight, while a load keeps being requested
    // out of range during the sweep.
    doStore(1, 8'hFF, 64'h0123456789ABCDEF, MICRO_SQ);
    applyStimulus(1, 8'h00, '0, 3'd0, MICRO_LQ);
    step();
    applyStimulus(16, 8'h00, '0, 3'd0, MICRO_LQ);
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {63'd0, ld_valid}, 64'd0);
    checkOutput("mid_rst_busy", {63'd0, busy}, 64'd1);
    checkOutput("mid_rst_addr_err", {63'd0, addr_err}, 64'd0);
    checkOutput("mid_rst_mis_err", {63'd0, misalign_err}, 64'd0);
    step();
    checkOutput("mid_rst_valid2", {63'd0, ld_valid}, 64'd0);
    rstn = 1'b1;
    waitSweep("sweep2");
    checkOutput("sweep_discard_flags", {63'd0, addr_err}, 64'd0);
    idle();
    doLoad("post_rst_lq1", 1, 3'd0, MICRO_LQ, 64'd0);

    step();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
